ifm_pingpong_ctrl: RTL and testbench
====================================

IFM_PINGPONG_CTRL -- requirements
Module: ifm_pingpong_ctrl

Interface
REQ-001 SHALL have parameter IFM_SIZE, default 9, the IFM side length in elements.
REQ-002 SHALL have parameter ADDRESS_SIZE_IFM, default $clog2(IFM_SIZE*IFM_SIZE) = 7, the bank address width.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: clk input 1, the single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1 bit: previous layer presents one IFM element this cycle.
REQ-006 SHALL have port wr_ready, output, 1 bit: the fill bank accepts an element.
REQ-007 SHALL have port ifm_enable_write_previous, output, 1 bit: write strobe to the memory array.
REQ-008 SHALL have port ifm_address_write_previous, output, ADDRESS_SIZE_IFM bits: write address to the memory array.
REQ-009 SHALL have port ifm_sel, output, 1 bit: bank select to the memory array; 0 = previous writes Mem1 and next reads Mem2, 1 = the reverse.
REQ-010 SHALL have port next_ready, output, 1 bit: the drain bank holds a complete IFM for the next layer.
REQ-011 SHALL have port next_done, input, 1 bit: single-cycle pulse, next layer has finished with the drain bank.
REQ-012 SHALL have port bank_swap, output, 1 bit: single-cycle pulse, registered, asserted in the cycle after a swap edge.
REQ-013 SHALL have port frame_count, output, 16 bits: number of completed swaps, wrapping modulo 2^16.

Function
REQ-014 SHALL keep these internal states: wr_cnt (ADDRESS_SIZE_IFM bits), fill_full flag, drain_valid flag, ifm_sel register.
REQ-015 SHALL drive wr_ready = !fill_full combinationally.
REQ-016 SHALL drive ifm_enable_write_previous = wr_valid & wr_ready combinationally (accept).
REQ-017 SHALL drive ifm_address_write_previous = wr_cnt.
REQ-018 SHALL increment wr_cnt by 1 on each accept while wr_cnt < IFM_SIZE*IFM_SIZE-1.
REQ-019 SHALL, on an accept with wr_cnt = IFM_SIZE*IFM_SIZE-1 (80), set wr_cnt to 0 and set fill_full to 1.
REQ-020 SHALL ignore wr_valid while fill_full = 1: no strobe, no counter change.
REQ-021 SHALL drive next_ready = drain_valid.
REQ-022 SHALL clear drain_valid on next_done when drain_valid = 1, and ignore next_done when drain_valid = 0.
REQ-023 SHALL evaluate the swap condition every edge: fill_full & (!drain_valid | next_done).
REQ-024 SHALL, on a swap edge, toggle ifm_sel, clear fill_full, set drain_valid to 1 (this overrides the next_done clear), increment frame_count, and set bank_swap to 1 for the following cycle.
REQ-025 SHALL NOT swap in the same edge on which the 81st element is accepted; the swap occurs at the earliest one edge later, so the final write lands in the old fill bank.
REQ-026 SHALL keep ifm_sel constant between swaps; a write in flight never changes bank.
REQ-027 SHALL, if fill_full = 1 and drain_valid = 1 with no next_done, hold all state, keep wr_ready = 0, and apply backpressure indefinitely.

Reset
REQ-028 SHALL, while reset = 1 at a clk edge, set wr_cnt=0, fill_full=0, drain_valid=0, ifm_sel=0, bank_swap=0, frame_count=0.
REQ-029 SHALL give reset priority over all inputs, including a mid-fill or mid-drain reset; partial fills are discarded.
REQ-030 SHALL, in the first cycle after reset, present wr_ready=1, next_ready=0, ifm_enable_write_previous=wr_valid.

Verification
REQ-031 SHALL be verified by scenario first fill: reset, then wr_valid=1 for 81 cycles -> addresses 0..80, ifm_sel=0 throughout, fill_full set after the 81st write; at the next edge ifm_sel=1, next_ready=1, bank_swap pulses once, frame_count=1, wr_ready=1.
REQ-032 SHALL be verified by scenario backpressure: second fill of 81 elements with no next_done -> wr_ready=0 from cycle 82 onward, no strobes, ifm_sel stays 1, next_ready stays 1.
REQ-033 SHALL be verified by scenario simultaneous release: while full and backpressured, pulse next_done -> at that same edge ifm_sel=0, next_ready remains 1, frame_count=2, writes resume at address 0.
REQ-034 SHALL be verified by scenario gapped input: wr_valid toggled 1/0 -> address advances only on accepted cycles, exactly 81 strobes per bank.
REQ-035 SHALL be verified by scenario spurious done: next_done pulsed while next_ready=0 -> no state change.
REQ-036 SHALL be verified by scenario mid-operation reset: reset asserted at wr_cnt=40 with drain_valid=1 -> next cycle all outputs match REQ-030, frame_count=0.

Source files
------------

// File: rtl/ifm_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_pingpong_ctrl
//
// Ping-pong controller for a two-bank input-feature-map (IFM) buffer.
// The previous layer streams one IFM (IFM_SIZE*IFM_SIZE elements) into the
// fill bank while the next layer consumes the other (drain) bank. When the
// fill bank is complete and the drain bank is free (or is being released in
// the same cycle), the banks are swapped.
//
// Ports
//   clk                         : single clock, all state on rising edge
//   reset                       : synchronous active-high reset
//   wr_valid                    : previous layer presents one element
//   wr_ready                    : fill bank can accept an element
//   ifm_enable_write_previous   : write strobe to the memory array
//   ifm_address_write_previous  : write address to the memory array
//   ifm_sel                     : bank select (0: write Mem1 / read Mem2)
//   next_ready                  : drain bank holds a complete IFM
//   next_done                   : pulse, next layer finished with drain bank
//   bank_swap                   : registered pulse, cycle after a swap edge
//   frame_count                 : number of completed swaps, modulo 2^16
// ---------------------------------------------------------------------------
module ifm_pingpong_ctrl #(
    parameter int IFM_SIZE         = 9,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        ifm_enable_write_previous,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
    output logic                        ifm_sel,
    output logic                        next_ready,
    input  logic                        next_done,
    output logic                        bank_swap,
    output logic [15:0]                 frame_count
);

    localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR =
        ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);

    logic [ADDRESS_SIZE_IFM-1:0] wr_cnt_r;
    logic                        fill_full_r;
    logic                        drain_valid_r;
    logic                        ifm_sel_r;
    logic                        bank_swap_r;
    logic [15:0]                 frame_count_r;

    logic                        accept_s;
    logic                        last_s;
    logic                        swap_s;
    logic [ADDRESS_SIZE_IFM-1:0] wr_cnt_nxt_s;
    logic                        fill_full_nxt_s;
    logic                        drain_valid_nxt_s;
    logic                        ifm_sel_nxt_s;
    logic [15:0]                 frame_count_nxt_s;

    // Handshake decode: accept, last element of a frame, and swap condition.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        swap_s   = 1'b0;
        accept_s = wr_valid & ~fill_full_r;
        last_s   = (wr_cnt_r == LAST_ADDR);
        // fill_full is only set after the last accept has been registered,
        // so the final element always lands in the old fill bank.
        swap_s   = fill_full_r & (~drain_valid_r | next_done);
    end

    // Next-state computation for the fill counter, bank flags and frame count.
    always_comb begin
        wr_cnt_nxt_s      = wr_cnt_r;
        fill_full_nxt_s   = fill_full_r;
        drain_valid_nxt_s = drain_valid_r;
        ifm_sel_nxt_s     = ifm_sel_r;
        frame_count_nxt_s = frame_count_r;
        if (swap_s) begin
            // A swap re-arms the drain bank even if next_done releases it now.
            ifm_sel_nxt_s     = ~ifm_sel_r;
            fill_full_nxt_s   = 1'b0;
            drain_valid_nxt_s = 1'b1;
            frame_count_nxt_s = frame_count_r + 16'd1;
        end else begin
            // Accept and swap are exclusive: accept needs !fill_full, swap needs fill_full.
            if (accept_s) begin
                if (last_s) begin
                    wr_cnt_nxt_s    = {ADDRESS_SIZE_IFM{1'b0}};
                    fill_full_nxt_s = 1'b1;
                end else begin
                    wr_cnt_nxt_s    = wr_cnt_r + ADDRESS_SIZE_IFM'(1);
                end
            end else begin
                wr_cnt_nxt_s = wr_cnt_r;
            end
            // next_done while nothing is being drained is ignored.
            if (next_done & drain_valid_r) begin
                drain_valid_nxt_s = 1'b0;
            end else begin
                drain_valid_nxt_s = drain_valid_r;
            end
        end
    end

    // State registers with synchronous reset; partial fills are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_r      <= {ADDRESS_SIZE_IFM{1'b0}};
            fill_full_r   <= 1'b0;
            drain_valid_r <= 1'b0;
            ifm_sel_r     <= 1'b0;
            bank_swap_r   <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            wr_cnt_r      <= wr_cnt_nxt_s;
            fill_full_r   <= fill_full_nxt_s;
            drain_valid_r <= drain_valid_nxt_s;
            ifm_sel_r     <= ifm_sel_nxt_s;
            bank_swap_r   <= swap_s;
            frame_count_r <= frame_count_nxt_s;
        end
    end

    assign wr_ready                   = ~fill_full_r;
    assign ifm_enable_write_previous  = accept_s;
    assign ifm_address_write_previous = wr_cnt_r;
    assign ifm_sel                    = ifm_sel_r;
    assign next_ready                 = drain_valid_r;
    assign bank_swap                  = bank_swap_r;
    assign frame_count                = frame_count_r;

endmodule

// File: tb/tb_ifm_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifm_pingpong_ctrl
//
// Self-checking bench for ifm_pingpong_ctrl. A behavioural model tracks the
// fill bank as an element count 0..N (N = frame size, "full" when it reaches
// N), a drain-busy flag, the bank select and a frame counter. Directed
// scenarios (first fill, backpressure, simultaneous release, spurious done,
// gapped input, mid-operation reset) are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_ifm_pingpong_ctrl;

    localparam int IFM_SIZE = 9;
    localparam int AW       = 7;
    localparam int N        = IFM_SIZE * IFM_SIZE;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic          ifm_enable_write_previous;
    logic [AW-1:0] ifm_address_write_previous;
    logic          ifm_sel;
    logic          next_ready;
    logic          next_done;
    logic          bank_swap;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    ifm_pingpong_ctrl #(.IFM_SIZE(IFM_SIZE), .ADDRESS_SIZE_IFM(AW)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .wr_valid                   (wr_valid),
        .wr_ready                   (wr_ready),
        .ifm_enable_write_previous  (ifm_enable_write_previous),
        .ifm_address_write_previous (ifm_address_write_previous),
        .ifm_sel                    (ifm_sel),
        .next_ready                 (next_ready),
        .next_done                  (next_done),
        .bank_swap                  (bank_swap),
        .frame_count                (frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_fill;     // elements held in the fill bank, N means full
    int m_drain;    // drain bank holds an IFM not yet released
    int m_sel;
    int m_frames;
    int m_swap;     // swap happened at the previous edge
    int strobes;    // DUT strobes observed since the last swap/reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model, then advance it.
    task automatic cycle();
        #2;
        chk("wr_ready",    {31'd0, wr_ready},                  32'(m_fill < N));
        chk("wr_strobe",   {31'd0, ifm_enable_write_previous}, 32'(wr_valid && (m_fill < N)));
        chk("wr_addr",     {25'd0, ifm_address_write_previous}, 32'(m_fill % N));
        chk("ifm_sel",     {31'd0, ifm_sel},                   32'(m_sel));
        chk("next_ready",  {31'd0, next_ready},                32'(m_drain));
        chk("bank_swap",   {31'd0, bank_swap},                 32'(m_swap));
        chk("frame_count", {16'd0, frame_count},               32'(m_frames % 65536));
        if (m_swap != 0) begin
            chk("strobes_per_bank", 32'(strobes), 32'(N));
            strobes = 0;
        end
        if (ifm_enable_write_previous === 1'b1) strobes++;
        @(posedge clk);
        if (reset) begin
            m_fill = 0; m_drain = 0; m_sel = 0; m_frames = 0; m_swap = 0; strobes = 0;
        end else begin
            if ((m_fill == N) && ((m_drain == 0) || next_done)) begin
                m_swap   = 1;
                m_sel    = 1 - m_sel;
                m_fill   = 0;
                m_drain  = 1;
                m_frames = m_frames + 1;
            end else begin
                m_swap = 0;
                if (wr_valid && (m_fill < N)) m_fill++;
                if (next_done) m_drain = 0;
            end
        end
        #1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; wr_valid = 1'b0; next_done = 1'b0;
        m_fill = 0; m_drain = 0; m_sel = 0; m_frames = 0; m_swap = 0; strobes = 0;
        @(posedge clk); @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_next_ready", {31'd0, next_ready}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);

        // First fill: 81 accepts, then the swap edge.
        wr_valid = 1'b1;
        repeat (N) cycle();
        #1;
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("full_sel", {31'd0, ifm_sel}, 32'd0);
        cycle();
        #1;
        chk("swap1_sel", {31'd0, ifm_sel}, 32'd1);
        chk("swap1_next_ready", {31'd0, next_ready}, 32'd1);
        chk("swap1_pulse", {31'd0, bank_swap}, 32'd1);
        chk("swap1_frames", {16'd0, frame_count}, 32'd1);
        chk("swap1_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Backpressure: second fill with no next_done.
        repeat (N + 5) cycle();
        #1;
        chk("bp_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("bp_strobe", {31'd0, ifm_enable_write_previous}, 32'd0);
        chk("bp_sel", {31'd0, ifm_sel}, 32'd1);
        chk("bp_next_ready", {31'd0, next_ready}, 32'd1);

        // Simultaneous release.
        next_done = 1'b1;
        cycle();
        next_done = 1'b0;
        #1;
        chk("rel_sel", {31'd0, ifm_sel}, 32'd0);
        chk("rel_next_ready", {31'd0, next_ready}, 32'd1);
        chk("rel_frames", {16'd0, frame_count}, 32'd2);
        chk("rel_addr", {25'd0, ifm_address_write_previous}, 32'd0);
        chk("rel_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Release the drain bank, then a spurious done.
        wr_valid = 1'b0; next_done = 1'b1;
        cycle();
        cycle();
        next_done = 1'b0;
        #1;
        chk("spur_next_ready", {31'd0, next_ready}, 32'd0);
        chk("spur_addr", {25'd0, ifm_address_write_previous}, 32'd0);
        chk("spur_sel", {31'd0, ifm_sel}, 32'd0);
        chk("spur_frames", {16'd0, frame_count}, 32'd2);

        // Gapped input: toggle wr_valid; address advances only on accepts.
        for (int i = 0; i < 2 * N + 10; i++) begin
            wr_valid = 1'((i % 2) == 0);
            cycle();
        end

        // Reach wr_cnt = 40 with the drain bank occupied, then reset.
        guard = 0;
        while (!((m_fill == 40) && (m_drain == 1)) && (guard < 400)) begin
            wr_valid  = 1'b1;
            next_done = 1'((m_fill == N) && (m_drain == 1));
            cycle();
            guard++;
        end
        next_done = 1'b0;
        chk("reach_mid_fill", 32'(guard < 400), 32'd1);
        chk("mid_addr", {25'd0, ifm_address_write_previous}, 32'd40);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("mrst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("mrst_next_ready", {31'd0, next_ready}, 32'd0);
        chk("mrst_strobe", {31'd0, ifm_enable_write_previous}, 32'd1);
        chk("mrst_addr", {25'd0, ifm_address_write_previous}, 32'd0);
        chk("mrst_frames", {16'd0, frame_count}, 32'd0);
        chk("mrst_sel", {31'd0, ifm_sel}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wr_valid  = 1'($urandom_range(0, 3) != 0);
            next_done = 1'($urandom_range(0, 7) == 0);
            reset     = 1'($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0; wr_valid = 1'b0; next_done = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
